// File: rtl/zjh_seg_scan.sv
// Multiplexed BCD-to-7-segment scanner: 4511-style latch/blank/lamp-test per digit,
// driving DIGITS common-cathode digits from one registered segment bus.
// Optional leading-zero blanking is enabled by defining ZJH_SEG_LZB_EN.
module zjh_seg_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  le,
    input  logic                  bi_n,
    input  logic                  lt_n,
    input  logic [4*DIGITS-1:0]   d,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] data_r;
    logic [CW-1:0]       cnt_r;
    logic [IW-1:0]       idx_r;
    logic [6:0]          seg_r;
    logic [DIGITS-1:0]   dig_sel_r;

    logic [3:0]          nib_s;
    logic [6:0]          seg_next_s;
    logic [DIGITS-1:0]   dig_next_s;

    function automatic logic [6:0] bcd_decode(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

`ifdef ZJH_SEG_LZB_EN
    logic [DIGITS-1:0] lzb_s;
    logic              zero_above_s;

    // Mark digits above 0 that are zero along with every digit more significant.
    always_comb begin
        lzb_s        = '0;
        zero_above_s = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above_s = zero_above_s & (data_r[4*k +: 4] == 4'd0);
            lzb_s[k]     = zero_above_s;
        end
    end
`endif

    // Next segment pattern and digit strobe for the currently indexed digit.
    always_comb begin
        nib_s      = data_r[int'(idx_r)*4 +: 4];
        dig_next_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig_next_s[k] = (idx_r == IW'(k));
        end
        if (!lt_n) begin
            seg_next_s = 7'h7F;
        end else if (!bi_n) begin
            seg_next_s = 7'h00;
        end else begin
`ifdef ZJH_SEG_LZB_EN
            if (lzb_s[idx_r]) begin
                seg_next_s = 7'h00;
            end else begin
                seg_next_s = bcd_decode(nib_s);
            end
`else
            seg_next_s = bcd_decode(nib_s);
`endif
        end
    end

    // Data latch, scan divider, digit index and the shared output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r    <= '0;
            cnt_r     <= '0;
            idx_r     <= '0;
            seg_r     <= 7'h00;
            dig_sel_r <= '0;
        end else begin
            if (!le) begin
                data_r <= d;
            end else begin
                data_r <= data_r;
            end
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
                if (idx_r == IDX_LAST) begin
                    idx_r <= '0;
                end else begin
                    idx_r <= idx_r + IW'(1);
                end
            end else begin
                cnt_r <= cnt_r + CW'(1);
                idx_r <= idx_r;
            end
            // seg and dig_sel share one stage so a new digit never shows stale segments.
            seg_r     <= seg_next_s;
            dig_sel_r <= dig_next_s;
        end
    end

    assign seg     = seg_r;
    assign dig_sel = dig_sel_r;

endmodule

// File: doc/zjh_seg_scan.md
Name: zjh_seg_scan

Overview:
- Parametrised, clocked successor to the single-digit 74HC4511 BCD-to-7-segment decoder.
- Drives DIGITS multiplexed common-cathode digits from one shared segment bus.
- Keeps 4511 semantics per digit: input latch (LE), blanking (BI), lamp test (LT), blanking of non-BCD codes.
- Adds a scan divider, digit rotation and one-hot digit select.
- Sits between the BCD datapath (counters, 74HC283 adder results) and the board display.

Parameters:
DIGITS, 4, number of digits scanned; legal range is DIGITS >= 1.
SCAN_DIV, 1000, clock cycles each digit stays selected; legal range is SCAN_DIV >= 1.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
le  input  1  latch enable: 0 = transparent (capture d each edge), 1 = hold latched data
bi_n  input  1  blanking, active low
lt_n  input  1  lamp test, active low; priority over bi_n
d  input  4*DIGITS  BCD data, digit k in d[4k+3:4k], digit 0 = least significant
seg  output  7  segments, seg[0]=a ... seg[6]=g, active high
dig_sel  output  DIGITS  one-hot digit enable, active high, bit k = digit k

Behaviour:
- Reset (rst=1 at an edge):
  - Latched data = 0, divider count = 0, digit index idx = 0.
  - seg = 7'h00, dig_sel = all zeros.
  - rst mid-scan aborts the scan immediately; no partial state survives.
- Latch: at each edge with rst=0 and le=0, the data register takes d; with le=1 it holds.
- Divider and digit index:
  - Counter runs 0..SCAN_DIV-1, width $clog2(SCAN_DIV) with a minimum of 1.
  - At the terminal count the counter returns to 0 and idx increments; idx wraps from DIGITS-1 to 0.
  - SCAN_DIV=1: idx advances every cycle.
  - DIGITS=1: idx stays 0.
- Outputs are registered and updated every cycle from current idx, latched data, lt_n and bi_n:
  - dig_sel <= one-hot(idx).
  - seg <= 7'h7F if lt_n=0; else 7'h00 if bi_n=0; else decode(latched nibble[idx]).
  - seg and dig_sel are always consistent: same register stage, no cycle where a new digit shows old segments.
- Latencies:
  - idx change -> dig_sel/seg: 1 cycle.
  - d -> seg (le=0, digit selected): 2 cycles.
  - lt_n/bi_n -> seg: 1 cycle.
- First edge after reset release: dig_sel = 1 (digit 0 selected). Digit 0 holds for SCAN_DIV cycles counting from reset release.
- Decode table:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 10..15 decode to 00 (blank, as the 4511 does).
- Scanning continues during lamp test and blanking.
- Simultaneous le falling and a digit switch: new data is used from the next edge per the 2-cycle rule.

Optional Feature:
- Macro: ZJH_SEG_LZB_EN (leading-zero blanking).
- When defined:
  - A digit k>0 decodes to 00 when it and every latched digit above it are 0.
  - Digit 0 is never suppressed.
  - lt_n and bi_n keep priority over suppression.
- When undefined: zeros always show as 3F.

Test Plan:
1. DIGITS=4, SCAN_DIV=4; rst=1 for 2 cycles -> seg=00, dig_sel=0000. Release -> next edge dig_sel=0001, and it holds 4 cycles.
2. le=0, d=16'h4321, lt_n=1, bi_n=1 -> seg/dig_sel sequence 06/0001, 5B/0010, 4F/0100, 66/1000, then wrap to 06/0001, each held 4 cycles.
3. After step 2 set le=1, then d=16'h9999 -> display still 4321 for a full scan. Set le=0 -> every digit shows 6F.
4. lt_n=0, bi_n=0 -> seg=7F on every digit while dig_sel keeps rotating. lt_n=1, bi_n=0 -> seg=00. bi_n=1 -> normal decode resumes 1 cycle later.
5. d=16'hFCBA -> seg=00 on all four digits. Assert rst mid-digit 2 -> next edge seg=00, dig_sel=0000, latched data 0.
6. With ZJH_SEG_LZB_EN: d=16'h0050 -> digits 3,2 show 00, digit 1 shows 6D, digit 0 shows 3F. d=16'h0000 -> digit 0 shows 3F, the others 00. d=16'h1000 -> all digits lit (06, 3F, 3F, 3F).
